pll_lock_sequencer: RTL and testbench

//  Sequences one Gowin rPLL (27 MHz in, 54 MHz out): holds PLL in reset, waits for LOCK,

---
 rtl/pll_ctrl_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/pll_lock_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for PLL control logic: sequencer states, rPLL phase
// interface width and the default duty offset (8 steps = 50% duty).
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        PH_SETTLE = 3'd4,
        LOST      = 3'd5,
        FAIL      = 3'd6
    } pll_state_t;

    localparam int PHASE_W             = 4;
    localparam int DEFAULT_DUTY_OFFSET = 8;

    // Largest of four timing parameters; sizes the one shared counter.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow level signals entering the clk domain.
// Each bit is synchronized independently, so multi-bit use is only valid
// for unrelated levels, not for buses that must be sampled coherently.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            // First stage may go metastable; second stage gives it a full cycle to resolve.
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up one rPLL: pulses its reset, waits for LOCK, qualifies lock
// stability, then releases the downstream system reset. Handles lock loss,
// bounded retries and run-time phase steps. All outputs except psda/dutyda
// and phase_ack are decoded from the registered state.
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int DUTY_OFFSET   = DEFAULT_DUTY_OFFSET,
    parameter int PHASE_SETTLE  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               pll_reset_p,
    output logic [PHASE_W-1:0] psda,
    output logic [PHASE_W-1:0] dutyda,
    input  logic               phase_req,
    input  logic [PHASE_W-1:0] phase_val,
    output logic               phase_ack,
    output logic               sys_rst,
    output logic               locked,
    output logic               fail,
    output logic [3:0]         retry_cnt
);

    localparam int CNT_MAX = max_of4(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, PHASE_SETTLE);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts: the counter runs 0..N-1 so each phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PHASE_LAST   = CNT_W'(PHASE_SETTLE - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]         RETRY_LIMIT  = 4'(MAX_RETRIES);
    localparam logic [PHASE_W-1:0] DUTY_OFF     = PHASE_W'(DUTY_OFFSET);

    pll_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         retry_reg, retry_next;
    logic [PHASE_W-1:0] psda_reg, psda_next;
    logic [PHASE_W-1:0] duty_reg, duty_next;
    logic               ack_reg, ack_next;
    logic               lock_sync;
    logic [3:0]         retry_inc;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_sync)
    );

    assign retry_inc = retry_reg + 4'd1;

    // State, shared counter, retry count and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= PLL_RST;
            cnt_reg   <= '0;
            retry_reg <= 4'd0;
            psda_reg  <= '0;
            duty_reg  <= DUTY_OFF;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            retry_reg <= retry_next;
            psda_reg  <= psda_next;
            duty_reg  <= duty_next;
            ack_reg   <= ack_next;
        end
    end

    // Next-state logic; a lock drop always takes priority over phase activity.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        psda_next  = psda_reg;
        duty_next  = duty_reg;
        ack_next   = 1'b0;
        case (state_reg)
            PLL_RST: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (lock_sync) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    cnt_next   = '0;
                    retry_next = retry_inc;
                    state_next = (retry_inc == RETRY_LIMIT) ? FAIL : PLL_RST;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            SETTLE: begin
                // Any low sample restarts qualification without charging a retry.
                if (!lock_sync) begin
                    cnt_next = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                    retry_next = 4'd0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            RUN: begin
                if (!lock_sync) begin
                    state_next = LOST;
                end else if (phase_req) begin
                    psda_next  = phase_val;
                    duty_next  = phase_val + DUTY_OFF;
                    state_next = PH_SETTLE;
                    cnt_next   = '0;
                end
            end
            PH_SETTLE: begin
                if (!lock_sync) begin
                    state_next = LOST;
                    cnt_next   = '0;
                end else if (cnt_reg == PHASE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                    ack_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            LOST: begin
                state_next = PLL_RST;
                cnt_next   = '0;
            end
            FAIL: begin
                state_next = FAIL;
            end
            default: begin
                state_next = PLL_RST;
                cnt_next   = '0;
            end
        endcase
    end

    assign pll_reset   = (state_reg == PLL_RST) || (state_reg == FAIL);
    assign pll_reset_p = pll_reset;
    assign sys_rst     = !((state_reg == RUN) || (state_reg == PH_SETTLE));
    assign locked      = (state_reg == RUN);
    assign fail        = (state_reg == FAIL);
    assign retry_cnt   = retry_reg;
    assign psda        = psda_reg;
    assign dutyda      = duty_reg;
    assign phase_ack   = ack_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scenario bench for pll_lock_sequencer with small timing parameters.
// Expected timings are derived from the sequencing rules with plain arithmetic.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 50;
    localparam int STABLE_CYCLES = 10;
    localparam int MAX_RETRIES   = 3;
    localparam int DUTY_OFFSET   = 8;
    localparam int PHASE_SETTLE  = 5;

    // Lock rise (raw) to sys_rst fall: 2 sync flops + 1 detect cycle + stable window.
    localparam int FIRST_LAT   = 2 + 1 + STABLE_CYCLES;
    // Re-rise inside the stable window: no detect cycle.
    localparam int RESTART_LAT = 2 + STABLE_CYCLES;
    localparam int ATTEMPT_LEN = RST_CYCLES + LOCK_TIMEOUT;
    localparam int FAIL_AT     = MAX_RETRIES * ATTEMPT_LEN;
    localparam int BUDGET      = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       pll_reset;
    logic       pll_reset_p;
    logic [3:0] psda;
    logic [3:0] dutyda;
    logic       phase_req;
    logic [3:0] phase_val;
    logic       phase_ack;
    logic       sys_rst;
    logic       locked;
    logic       fail;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .DUTY_OFFSET   (DUTY_OFFSET),
        .PHASE_SETTLE  (PHASE_SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_reset_p (pll_reset_p),
        .psda        (psda),
        .dutyda      (dutyda),
        .phase_req   (phase_req),
        .phase_val   (phase_val),
        .phase_ack   (phase_ack),
        .sys_rst     (sys_rst),
        .locked      (locked),
        .fail        (fail),
        .retry_cnt   (retry_cnt)
    );

    function automatic logic [3:0] duty_of(input int v);
        return 4'((v + DUTY_OFFSET) % 16);
    endfunction

    function automatic logic [17:0] reset_vec();
        logic [3:0] d;
        d = 4'(DUTY_OFFSET);
        return {1'b1, 1'b1, 4'd0, d, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_lock = 1'b0;
        phase_req = 1'b0;
        phase_val = 4'd0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Counts cycles pll_reset stays high, starting with the current cycle.
    task automatic measure_reset_pulse(output int width);
        width = 0;
        while (pll_reset === 1'b1 && width < BUDGET) begin
            width++;
            tick();
        end
    endtask

    // Cycles until sys_rst deasserts; -1 if it never does within the budget.
    task automatic wait_release(output int n);
        n = 0;
        while (sys_rst !== 1'b0 && n < BUDGET) begin
            tick();
            n++;
        end
        if (n >= BUDGET) n = -1;
    endtask

    task automatic bring_up(input int d, output int width, output int lat);
        measure_reset_pulse(width);
        repeat (d) tick();
        pll_lock = 1'b1;
        wait_release(lat);
    endtask

    // Cycles until phase_ack pulses; -1 if it never does. Also reports any sys_rst activity.
    task automatic wait_ack(output int n, output logic saw_sys_rst);
        n = 0;
        saw_sys_rst = 1'b0;
        while (phase_ack !== 1'b1 && n < 50) begin
            tick();
            n++;
            if (sys_rst !== 1'b0) saw_sys_rst = 1'b1;
        end
        if (n >= 50) n = -1;
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rst = 1'b1;
        pll_lock = 1'b1;
        phase_req = 1'b0;
        phase_val = 4'd0;
        repeat (2) tick();
        obs = {pll_reset, pll_reset_p, psda, dutyda, phase_ack, sys_rst, locked, fail, retry_cnt};
        checks++;
        if (obs !== reset_vec()) begin
            errors++;
            $display("FAIL reset_vec: got %h expected %h", obs, reset_vec());
        end
        checks++;
        if (dutyda !== 4'(DUTY_OFFSET)) begin
            errors++;
            $display("FAIL reset_dutyda: got %0d expected %0d", dutyda, DUTY_OFFSET);
        end
        $display("reset: outputs %h", obs);
    endtask

    task automatic test_bring_up();
        int w;
        int lat;
        int d;
        for (int it = 0; it < 3; it++) begin
            d = (it == 0) ? 20 : int'($urandom_range(0, 40));
            do_reset();
            bring_up(d, w, lat);
            checks++;
            if (w != RST_CYCLES) begin
                errors++;
                $display("FAIL bringup_pulse: got %0d expected %0d", w, RST_CYCLES);
            end
            checks++;
            if (lat != FIRST_LAT) begin
                errors++;
                $display("FAIL bringup_latency: got %0d expected %0d", lat, FIRST_LAT);
            end
            checks++;
            if ({locked, pll_reset, fail, retry_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
                errors++;
                $display("FAIL bringup_status: got locked=%0b pll_reset=%0b fail=%0b retry=%0d expected 1 0 0 0",
                         locked, pll_reset, fail, retry_cnt);
            end
            $display("bringup: delay=%0d pulse=%0d release_after=%0d", d, w, lat);
        end
    endtask

    task automatic test_lock_timeout();
        logic       exp_reset;
        logic       exp_fail;
        logic [3:0] exp_retry;
        int         bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < FAIL_AT + 60; i++) begin
            exp_fail  = (i >= FAIL_AT);
            exp_reset = exp_fail || ((i % ATTEMPT_LEN) < RST_CYCLES);
            exp_retry = 4'((i / ATTEMPT_LEN) > MAX_RETRIES ? MAX_RETRIES : (i / ATTEMPT_LEN));
            checks++;
            if ({pll_reset, pll_reset_p, fail, retry_cnt} !== {exp_reset, exp_reset, exp_fail, exp_retry}) begin
                errors++;
                bad++;
                $display("FAIL timeout_seq cycle %0d: got rst=%0b rst_p=%0b fail=%0b retry=%0d expected %0b %0b %0b %0d",
                         i, pll_reset, pll_reset_p, fail, retry_cnt, exp_reset, exp_reset, exp_fail, exp_retry);
            end
            tick();
        end
        checks++;
        if ({sys_rst, locked} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_fail_outputs: got sys_rst=%0b locked=%0b expected 1 0", sys_rst, locked);
        end
        $display("timeout: %0d cycles observed, %0d off-model", FAIL_AT + 60, bad);
        do_reset();
        checks++;
        if ({fail, retry_cnt, pll_reset} !== {1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_rst_clears: got fail=%0b retry=%0d pll_reset=%0b expected 0 0 1",
                     fail, retry_cnt, pll_reset);
        end
    endtask

    task automatic test_settle_glitch();
        int w;
        int d;
        int g;
        int n;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            measure_reset_pulse(w);
            d = int'($urandom_range(0, 30));
            repeat (d) tick();
            pll_lock = 1'b1;
            g = int'($urandom_range(1, 9));
            repeat (g) tick();
            pll_lock = 1'b0;
            tick();
            pll_lock = 1'b1;
            wait_release(n);
            checks++;
            if (n != RESTART_LAT) begin
                errors++;
                $display("FAIL glitch_restart: got %0d expected %0d", n, RESTART_LAT);
            end
            checks++;
            if ({retry_cnt, locked} !== {4'd0, 1'b1}) begin
                errors++;
                $display("FAIL glitch_retry: got retry=%0d locked=%0b expected 0 1", retry_cnt, locked);
            end
            $display("glitch: offset=%0d release_after_rerise=%0d", g, n);
        end
    endtask

    task automatic test_phase_change();
        int         w;
        int         lat;
        int         v;
        int         n;
        logic       saw;
        logic [3:0] other;
        do_reset();
        bring_up(int'($urandom_range(0, 30)), w, lat);
        for (int it = 0; it < 4; it++) begin
            v = (it == 0) ? 12 : int'($urandom_range(0, 15));
            phase_val = 4'(v);
            phase_req = 1'b1;
            tick();
            phase_req = 1'b0;
            checks++;
            if ({psda, dutyda, locked, sys_rst, phase_ack} !== {4'(v), duty_of(v), 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL phase_update: got psda=%0d duty=%0d locked=%0b sys_rst=%0b ack=%0b expected %0d %0d 0 0 0",
                         psda, dutyda, locked, sys_rst, phase_ack, v, duty_of(v));
            end
            // A request while settling must be ignored, not queued.
            other = ~4'(v);
            phase_val = other;
            phase_req = 1'b1;
            tick();
            phase_req = 1'b0;
            wait_ack(n, saw);
            n = (n < 0) ? -1 : n + 1;
            checks++;
            if (n != PHASE_SETTLE) begin
                errors++;
                $display("FAIL phase_ack_delay: got %0d expected %0d", n, PHASE_SETTLE);
            end
            checks++;
            if (saw !== 1'b0 || sys_rst !== 1'b0) begin
                errors++;
                $display("FAIL phase_sys_rst: got %0b expected 0", saw | sys_rst);
            end
            checks++;
            if (psda !== 4'(v)) begin
                errors++;
                $display("FAIL phase_ignored_req: got psda=%0d expected %0d", psda, v);
            end
            tick();
            checks++;
            if ({phase_ack, locked} !== 2'b01) begin
                errors++;
                $display("FAIL phase_ack_pulse: got ack=%0b locked=%0b expected 0 1", phase_ack, locked);
            end
            $display("phase: val=%0d psda=%0d dutyda=%0d ack_after=%0d", v, psda, dutyda, n);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_drop_with_req();
        int   w;
        int   lat;
        int   v0;
        int   n;
        logic saw;
        do_reset();
        bring_up(int'($urandom_range(0, 30)), w, lat);
        v0 = int'($urandom_range(1, 15));
        phase_val = 4'(v0);
        phase_req = 1'b1;
        tick();
        phase_req = 1'b0;
        wait_ack(n, saw);
        tick();
        pll_lock = 1'b0;
        tick();
        tick();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL drop_sync_latency: got locked=%0b expected 1", locked);
        end
        phase_val = ~4'(v0);
        phase_req = 1'b1;
        tick();
        phase_req = 1'b0;
        checks++;
        if ({sys_rst, locked, psda, phase_ack, pll_reset} !== {1'b1, 1'b0, 4'(v0), 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drop_lost: got sys_rst=%0b locked=%0b psda=%0d ack=%0b pll_reset=%0b expected 1 0 %0d 0 0",
                     sys_rst, locked, psda, phase_ack, pll_reset, v0);
        end
        tick();
        checks++;
        if (pll_reset !== 1'b1) begin
            errors++;
            $display("FAIL drop_pll_rst: got %0b expected 1", pll_reset);
        end
        bring_up(int'($urandom_range(0, 30)), w, lat);
        checks++;
        if (w != RST_CYCLES || lat != FIRST_LAT) begin
            errors++;
            $display("FAIL drop_relock: got pulse=%0d latency=%0d expected %0d %0d", w, lat, RST_CYCLES, FIRST_LAT);
        end
        checks++;
        if ({psda, dutyda, locked} !== {4'(v0), duty_of(v0), 1'b1}) begin
            errors++;
            $display("FAIL drop_phase_kept: got psda=%0d duty=%0d locked=%0b expected %0d %0d 1",
                     psda, dutyda, locked, v0, duty_of(v0));
        end
        $display("drop: phase=%0d relock pulse=%0d release_after=%0d", v0, w, lat);
    endtask

    task automatic test_rst_mid_phase();
        int          w;
        int          lat;
        int          v;
        logic [17:0] obs;
        do_reset();
        bring_up(int'($urandom_range(0, 30)), w, lat);
        v = int'($urandom_range(1, 15));
        phase_val = 4'(v);
        phase_req = 1'b1;
        tick();
        phase_req = 1'b0;
        checks++;
        if (psda !== 4'(v)) begin
            errors++;
            $display("FAIL midrst_pre: got psda=%0d expected %0d", psda, v);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        obs = {pll_reset, pll_reset_p, psda, dutyda, phase_ack, sys_rst, locked, fail, retry_cnt};
        checks++;
        if (obs !== reset_vec()) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected %h", obs, reset_vec());
        end
        rst = 1'b0;
        $display("midrst: phase=%0d outputs after rst %h", v, obs);
    endtask

    initial begin
        rst = 1'b1;
        pll_lock = 1'b0;
        phase_req = 1'b0;
        phase_val = 4'd0;
        test_reset();
        test_bring_up();
        test_lock_timeout();
        test_settle_glitch();
        test_phase_change();
        test_drop_with_req();
        test_rst_mid_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
